dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter n, default 32, data/address width.
REQ-002 SHALL have parameter BURST_MAX, default 4, max consecutive beats before forced handover (ROUND_ROBIN_EN builds only).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports p0_req, p1_req  input  1 each  access request (p0 = CPU, p1 = loader/debug).
REQ-006 SHALL have ports p0_we, p1_we  input  1 each  write enable; 0 = read.
REQ-007 SHALL have ports p0_addr, p1_addr, p0_wdata, p1_wdata  input  n each  address and write data.
REQ-008 SHALL have ports p0_gnt, p1_gnt  output  1 each  beat accepted this cycle.
REQ-009 SHALL have ports p0_rdata, p1_rdata  output  n each  registered read data.
REQ-010 SHALL have ports p0_rvalid, p1_rvalid  output  1 each  one-cycle read-data-valid pulse.
REQ-011 SHALL have ports mem_we  output  1; mem_addr, mem_wdata  output  n; mem_rdata  input  n; single dmem port (combinational read, write on clk edge).

Function
REQ-012 SHALL implement states IDLE, OWN0, OWN1; state, beat counter and last_served SHALL be registered.
REQ-013 SHALL assert px_gnt = (state==OWNx) & px_req, combinationally; never both gnts in one cycle.
REQ-014 SHALL drive mem_addr/mem_wdata from owner port and mem_we = gnt & px_we; in IDLE, or owner req low: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-015 SHALL capture mem_rdata into px_rdata on the edge ending a granted read beat and pulse px_rvalid the following cycle; px_rdata SHALL hold until the next read for that port.
REQ-016 Latency: req first high in IDLE at cycle t -> gnt at t+1 -> write committed at end of t+1 / rvalid at t+2.
REQ-017 Requester SHALL hold addr/we/wdata stable while req high and gnt low; each granted cycle is one beat; back-to-back beats allowed.
REQ-018 IDLE: single requester -> its OWN state; none -> stay IDLE; both -> per REQ-024/REQ-025.
REQ-019 OWNx with px_req low at edge: other requesting -> OWN_other, else IDLE.
REQ-020 Beat counter (ceil(log2(BURST_MAX))+1 bits) SHALL clear on every ownership change and increment per granted beat, saturating at BURST_MAX.
REQ-021 last_served SHALL update to x on entering OWNx.
REQ-022 Simultaneous owner drop and other-port rise SHALL hand over with no IDLE bubble.
REQ-023 A request arriving while other port owns SHALL wait without its gnt; no request SHALL be lost.

Configuration
REQ-024 With ROUND_ROBIN_EN defined: IDLE tie -> port != last_served; OWNx with px_req high stays until counter reaches BURST_MAX, then switches if other requests, else counter clears and ownership continues.
REQ-025 Without ROUND_ROBIN_EN: fixed priority, p0 wins every tie; OWN1 releases to OWN0 after any beat with p0_req high; OWN0 retains while p0_req high (p1 may starve); BURST_MAX unused.

Reset
REQ-026 reset low SHALL immediately force state=IDLE, counter=0, last_served=1, all gnt/rvalid=0, all rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, independent of clk.
REQ-027 Reset mid-beat SHALL abort the beat (mem_we drops asynchronously); no rvalid SHALL follow; first grant SHALL occur no earlier than one edge after reset release.

Verification
REQ-028 p0 write addr 0x10 data 0xDEADBEEF alone -> p0_gnt cycle t+1, mem_we=1 addr 0x10; p0 read 0x10 -> p0_rvalid at t+2, p0_rdata=0xDEADBEEF.
REQ-029 Both req continuously, ROUND_ROBIN_EN, BURST_MAX=4 -> first OWN0, gnt pattern 4x p0, 4x p1, 4x p0; never overlapping gnts.
REQ-030 Both req continuously, no macro -> p0_gnt every cycle, p1_gnt never; drop p0_req -> p1_gnt next cycle.
REQ-031 p0 owns, drops req same cycle p1 rises -> p1_gnt next cycle, no IDLE cycle, counter restarts at 0.
REQ-032 reset low during p1 write beat to 0x20 -> mem_we 0 immediately, no rvalid, location 0x20 unchanged, state IDLE after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates two requesters (p0 = CPU, p1 = loader/debug) onto one data-memory port.
// Define ROUND_ROBIN_EN for round-robin ties with a BURST_MAX beat limit; default build is fixed p0 priority.
module dmem_arbiter #(
    parameter int n         = 32,
    parameter int BURST_MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         p0_req,
    input  logic         p1_req,
    input  logic         p0_we,
    input  logic         p1_we,
    input  logic [n-1:0] p0_addr,
    input  logic [n-1:0] p1_addr,
    input  logic [n-1:0] p0_wdata,
    input  logic [n-1:0] p1_wdata,
    output logic         p0_gnt,
    output logic         p1_gnt,
    output logic [n-1:0] p0_rdata,
    output logic [n-1:0] p1_rdata,
    output logic         p0_rvalid,
    output logic         p1_rvalid,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata
);
    localparam int CW = $clog2(BURST_MAX) + 1;
    localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_next, other;
    logic [CW-1:0] cnt, cnt_next, cnt_inc;
    logic          last, last_next;
    logic          own_req, other_req;

    assign p0_gnt    = (state == OWN0) & p0_req;
    assign p1_gnt    = (state == OWN1) & p1_req;
    assign mem_we    = p0_gnt ? p0_we : p1_gnt ? p1_we : 1'b0;
    assign mem_addr  = p0_gnt ? p0_addr : p1_gnt ? p1_addr : '0;
    assign mem_wdata = p0_gnt ? p0_wdata : p1_gnt ? p1_wdata : '0;
    assign other     = (state == OWN0) ? OWN1 : OWN0;
    assign own_req   = (state == OWN0) ? p0_req : p1_req;
    assign other_req = (state == OWN0) ? p1_req : p0_req;
    assign cnt_inc   = (cnt == BMAX) ? cnt : cnt + 1'b1;

    // Next owner, beat count and last-served selection
    always_comb begin
        state_next = state;
        cnt_next   = (p0_gnt | p1_gnt) ? cnt_inc : cnt;
        last_next  = last;
        unique case (state)
            IDLE: begin
                if (p0_req && p1_req) begin
`ifdef ROUND_ROBIN_EN
                    state_next = last ? OWN0 : OWN1;
`else
                    state_next = OWN0;
`endif
                end else if (p0_req) begin
                    state_next = OWN0;
                end else if (p1_req) begin
                    state_next = OWN1;
                end
            end
            default: begin
                if (!own_req) begin
                    state_next = other_req ? other : IDLE;
`ifdef ROUND_ROBIN_EN
                end else if (cnt_inc == BMAX) begin
                    if (other_req)
                        state_next = other;
                    else
                        cnt_next = '0;
`else
                end else if (state == OWN1 && p0_req) begin
                    state_next = OWN0;
`endif
                end
            end
        endcase
        if (state_next != state)
            cnt_next = '0;
        if (state_next == OWN0 && state != OWN0)
            last_next = 1'b0;
        if (state_next == OWN1 && state != OWN1)
            last_next = 1'b1;
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            last  <= last_next;
        end
    end

    // Capture read data at the end of a granted read beat and pulse rvalid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt & ~p0_we)
                p0_rdata <= mem_rdata;
            if (p1_gnt & ~p1_we)
                p1_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level reference model
module tb_dmem_arbiter;
    localparam int BM = 4;
`ifdef ROUND_ROBIN_EN
    localparam bit RR      = 1'b1;
    localparam int EXP_RUN = BM;
`else
    localparam bit RR      = 1'b0;
    localparam int EXP_RUN = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;
    int          checks = 0;
    int          errors = 0;

    bit   [31:0] mem [64];

    dmem_arbiter #(.n(32), .BURST_MAX(BM)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: combinational read, write on rising edge
    assign mem_rdata = mem[mem_addr[5:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 0;
        p0_req = 1; p1_req = 1; p0_we = 1; p1_we = 1; p0_addr = 32'h5; p1_addr = 32'h6;
        #1;
        checks++;
        if ({p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {p0_gnt, p1_gnt, mem_we, p0_rvalid, p1_rvalid});
        end
        checks++;
        if ({mem_addr, mem_wdata, p0_rdata, p1_rdata} !== 128'h0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h want 0", mem_addr, mem_wdata, p0_rdata, p1_rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin
            errors++; $display("FAIL reset_hold_gnt got %b want 00", {p0_gnt, p1_gnt});
        end
        next_cycle();
        reset = 1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b0) begin
            errors++; $display("FAIL reset_release got %b want 0000", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid});
        end
    endtask

    task automatic test_write_read;
        next_cycle();
        p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (p0_gnt !== 1'b0) begin errors++; $display("FAIL wr_first_cycle_gnt got %b want 0", p0_gnt); end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({p0_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL wr_beat got gnt=%b we=%b a=%h d=%h want 1 1 10 deadbeef", p0_gnt, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        p0_we = 0;
        @(negedge clk);
        checks++;
        if ({p0_gnt, mem_we, p0_rvalid} !== 3'b100 || mem[16] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_beat got gnt=%b we=%b rv=%b mem=%h want 1 0 0 deadbeef", p0_gnt, mem_we, p0_rvalid, mem[16]);
        end
        next_cycle();
        p0_req = 0;
        @(negedge clk);
        checks++;
        if ({p0_rvalid, p0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL p0_rdata got rv=%b d=%h want 1 deadbeef", p0_rvalid, p0_rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({p0_rvalid, p0_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            errors++; $display("FAIL p0_rdata_hold got rv=%b d=%h want 0 deadbeef", p0_rvalid, p0_rdata);
        end
        next_cycle();
        p1_req = 1; p1_we = 0; p1_addr = 32'h10;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({p1_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
            errors++; $display("FAIL p1_read_gnt got gnt=%b we=%b a=%h want 1 0 10", p1_gnt, mem_we, mem_addr);
        end
        next_cycle();
        p1_req = 0;
        @(negedge clk);
        checks++;
        if ({p1_rvalid, p1_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL p1_rdata got rv=%b d=%h want 1 deadbeef", p1_rvalid, p1_rdata);
        end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_both_continuous;
        next_cycle();
        p0_req = 1; p1_req = 1; p0_we = 0; p1_we = 0; p0_addr = 32'h11; p1_addr = 32'h12;
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin errors++; $display("FAIL tie_first_cycle got %b want 00", {p0_gnt, p1_gnt}); end
`ifdef ROUND_ROBIN_EN
        for (int k = 0; k < 3 * BM; k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if ({p0_gnt, p1_gnt} !== (((k / BM) % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rr_pattern beat %0d got %b want %b", k, {p0_gnt, p1_gnt}, ((k / BM) % 2 == 0) ? 2'b10 : 2'b01);
            end
        end
`else
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if ({p0_gnt, p1_gnt} !== 2'b10) begin
                errors++; $display("FAIL prio_pattern beat %0d got %b want 10", k, {p0_gnt, p1_gnt});
            end
        end
        next_cycle();
        p0_req = 0;
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin errors++; $display("FAIL prio_drop got %b want 00", {p0_gnt, p1_gnt}); end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b01) begin errors++; $display("FAIL prio_p1_after_drop got %b want 01", {p0_gnt, p1_gnt}); end
`endif
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_handover;
        int run;
        next_cycle();
        p0_req = 1; p0_we = 1; p0_addr = 32'h13; p0_wdata = 32'h1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (p0_gnt !== 1'b1) begin errors++; $display("FAIL ho_p0_owns got %b want 1", p0_gnt); end
        next_cycle();
        next_cycle();
        p0_req = 0; p1_req = 1; p1_we = 1; p1_addr = 32'h14; p1_wdata = 32'h2;
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin errors++; $display("FAIL ho_drop_cycle got %b want 00", {p0_gnt, p1_gnt}); end
        next_cycle();
        p0_req = 1;
        @(negedge clk);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b01) begin errors++; $display("FAIL ho_no_bubble got %b want 01", {p0_gnt, p1_gnt}); end
        run = 1;
        for (int k = 0; k < 12; k++) begin
            next_cycle();
            @(negedge clk);
            if (!p1_gnt) break;
            run++;
        end
        checks++;
        if (run !== EXP_RUN || p0_gnt !== 1'b1) begin
            errors++; $display("FAIL ho_p1_run got %0d beats p0_gnt=%b want %0d beats p0_gnt=1", run, p0_gnt, EXP_RUN);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid_beat;
        next_cycle();
        p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h12345678;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({p1_gnt, mem_we, mem_addr} !== {1'b1, 1'b1, 32'h20}) begin
            errors++; $display("FAIL rst_beat_pre got gnt=%b we=%b a=%h want 1 1 20", p1_gnt, mem_we, mem_addr);
        end
        #1 reset = 0;
        #1;
        checks++;
        if ({p1_gnt, mem_we, mem_addr, p1_rdata} !== 66'h0) begin
            errors++; $display("FAIL rst_async got gnt=%b we=%b a=%h rd=%h want 0", p1_gnt, mem_we, mem_addr, p1_rdata);
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        checks++;
        if ({p1_gnt, p1_rvalid} !== 2'b00 || mem[32] !== 32'h0) begin
            errors++; $display("FAIL rst_after_release got gnt=%b rv=%b mem=%h want 0 0 0", p1_gnt, p1_rvalid, mem[32]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({p1_gnt, p1_rvalid} !== 2'b10) begin
            errors++; $display("FAIL rst_first_grant got gnt=%b rv=%b want 1 0", p1_gnt, p1_rvalid);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_random;
        int          owner, beats, last, nxt;
        bit          r [2];
        bit          g0, g1, pg0, pg1, erv0, erv1, e_we;
        logic [31:0] erd0, erd1, e_addr, e_wd;
        bit   [31:0] ref_mem [64];
        next_cycle();
        idle_inputs();
        reset = 0;
        next_cycle();
        reset = 1;
        owner = -1; beats = 0; last = 1;
        erv0 = 0; erv1 = 0; erd0 = 0; erd1 = 0; pg0 = 0; pg1 = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            next_cycle();
            if (!(p0_req && !pg0)) begin
                p0_req = $urandom_range(0, 3) != 0; p0_we = 1'($urandom_range(0, 1));
                p0_addr = 32'h30 + 32'($urandom_range(0, 15)); p0_wdata = $urandom;
            end
            if (!(p1_req && !pg1)) begin
                p1_req = $urandom_range(0, 3) != 0; p1_we = 1'($urandom_range(0, 1));
                p1_addr = 32'h30 + 32'($urandom_range(0, 15)); p1_wdata = $urandom;
            end
            @(negedge clk);
            g0 = owner == 0 && p0_req;
            g1 = owner == 1 && p1_req;
            e_we = g0 ? p0_we : g1 ? p1_we : 1'b0;
            e_addr = g0 ? p0_addr : g1 ? p1_addr : 32'h0;
            e_wd = g0 ? p0_wdata : g1 ? p1_wdata : 32'h0;
            checks++;
            if ({p0_gnt, p1_gnt} !== {g0, g1}) begin
                errors++; $display("FAIL rnd_gnt cyc %0d got %b want %b", cyc, {p0_gnt, p1_gnt}, {g0, g1});
            end
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {e_we, e_addr, e_wd}) begin
                errors++; $display("FAIL rnd_mem cyc %0d got %b %h %h want %b %h %h", cyc, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wd);
            end
            checks++;
            if ({p0_rvalid, p1_rvalid, p0_rdata, p1_rdata} !== {erv0, erv1, erd0, erd1}) begin
                errors++; $display("FAIL rnd_read cyc %0d got %b%b %h %h want %b%b %h %h", cyc, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, erv0, erv1, erd0, erd1);
            end
            erv0 = g0 && !p0_we;
            erv1 = g1 && !p1_we;
            if (erv0) erd0 = ref_mem[p0_addr[5:0]];
            if (erv1) erd1 = ref_mem[p1_addr[5:0]];
            if (e_we) ref_mem[e_addr[5:0]] = e_wd;
            r[0] = p0_req; r[1] = p1_req;
            nxt = owner;
            if (owner < 0) begin
                if (r[0] && r[1]) nxt = RR ? 1 - last : 0;
                else if (r[0]) nxt = 0;
                else if (r[1]) nxt = 1;
            end else if (!r[owner]) begin
                nxt = r[1 - owner] ? 1 - owner : -1;
            end else begin
                beats++;
                if (RR && beats == BM) begin
                    if (r[1 - owner]) nxt = 1 - owner;
                    else beats = 0;
                end
                if (!RR && owner == 1 && r[0]) nxt = 0;
            end
            if (nxt != owner) begin
                beats = 0;
                if (nxt >= 0) last = nxt;
            end
            owner = nxt;
            pg0 = g0; pg1 = g1;
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_both_continuous();
        test_handover();
        test_reset_mid_beat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
